issue_queue: RTL and testbench

Parametrised in-order issue buffer between Decode and the execution functional units.
- Holds up to DEPTH decoded instructions.
- Tracks in-flight destination registers in an internal scoreboard and reads operands from the ARF for the head entry.
- Issues the head entry to exactly one of NUM_UNITS units over a valid/ready handshake when its hazards are clear.
- Replaces the single-slot, stall-only issue stage. Adds queueing, per-unit backpressure, flush and stall accounting.

---
 rtl/issue_queue_if.sv | 61 ++++++
 rtl/issue_queue.sv | 183 ++++++++++++++++++
 tb/tb_issue_queue.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_if.sv
// Issue-queue port bundle: Decode enqueue, ARF read, functional-unit issue, writeback, flush, stats.
// Latency: none (wiring only).
// Backpressure: carries id_iss_ready toward Decode and per-unit ex_iss_ready toward the queue.
interface issue_queue_if #(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_UNITS = 3,
    parameter int PAYLOAD_W = 64
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Decode -> queue
    logic                 id_iss_valid;
    logic                 id_iss_ready;
    logic [PAYLOAD_W-1:0] id_iss_payload;
    logic [NUM_UNITS-1:0] id_iss_unit;
    logic [ADDR_W-1:0]    id_iss_addra;
    logic [ADDR_W-1:0]    id_iss_addrb;
    logic                 id_iss_check_a;
    logic                 id_iss_check_b;
    logic [ADDR_W-1:0]    id_iss_regdest;
    logic                 id_iss_writereg;
    // ARF read for the head entry
    logic [ADDR_W-1:0]    iss_reg_addra;
    logic [ADDR_W-1:0]    iss_reg_addrb;
    logic [DATA_W-1:0]    reg_iss_dataa;
    logic [DATA_W-1:0]    reg_iss_datab;
    // Queue -> functional units
    logic [NUM_UNITS-1:0] iss_ex_valid;
    logic [NUM_UNITS-1:0] ex_iss_ready;
    logic [PAYLOAD_W-1:0] iss_ex_payload;
    logic [DATA_W-1:0]    iss_ex_rega;
    logic [DATA_W-1:0]    iss_ex_regb;
    logic [ADDR_W-1:0]    iss_ex_regdest;
    logic                 iss_ex_writereg;
    // Writeback, flush, statistics
    logic                 wb_iss_valid;
    logic [ADDR_W-1:0]    wb_iss_addr;
    logic                 iss_flush;
    logic [CNT_W-1:0]     iss_count;
    logic [15:0]          iss_stall_cycles;

    // Environment side (Decode, ARF, units, writeback)
    modport master (
        output id_iss_valid, id_iss_payload, id_iss_unit, id_iss_addra, id_iss_addrb,
               id_iss_check_a, id_iss_check_b, id_iss_regdest, id_iss_writereg,
               reg_iss_dataa, reg_iss_datab, ex_iss_ready, wb_iss_valid, wb_iss_addr, iss_flush,
        input  id_iss_ready, iss_reg_addra, iss_reg_addrb, iss_ex_valid, iss_ex_payload,
               iss_ex_rega, iss_ex_regb, iss_ex_regdest, iss_ex_writereg, iss_count, iss_stall_cycles
    );

    // Issue-queue side
    modport slave (
        input  id_iss_valid, id_iss_payload, id_iss_unit, id_iss_addra, id_iss_addrb,
               id_iss_check_a, id_iss_check_b, id_iss_regdest, id_iss_writereg,
               reg_iss_dataa, reg_iss_datab, ex_iss_ready, wb_iss_valid, wb_iss_addr, iss_flush,
        output id_iss_ready, iss_reg_addra, iss_reg_addrb, iss_ex_valid, iss_ex_payload,
               iss_ex_rega, iss_ex_regb, iss_ex_regdest, iss_ex_writereg, iss_count, iss_stall_cycles
    );
endinterface

// File: rtl/issue_queue.sv
// In-order issue queue with register scoreboard, ARF read of the head and a one-entry output slot.
// Latency: enqueue at edge N, earliest issue at edge N+1 (no pass-through), one issue per cycle.
// Backpressure: id_iss_ready low when full; head held on hazard or when the slot is held by its unit.
module issue_queue #(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_UNITS = 3,
    parameter int PAYLOAD_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    issue_queue_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int NREG  = 1 << ADDR_W;

    // Queue storage
    logic [PAYLOAD_W-1:0] r_q_payload  [DEPTH];
    logic [NUM_UNITS-1:0] r_q_unit     [DEPTH];
    logic [ADDR_W-1:0]    r_q_addra    [DEPTH];
    logic [ADDR_W-1:0]    r_q_addrb    [DEPTH];
    logic                 r_q_check_a  [DEPTH];
    logic                 r_q_check_b  [DEPTH];
    logic [ADDR_W-1:0]    r_q_regdest  [DEPTH];
    logic                 r_q_writereg [DEPTH];

    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;
    logic [NREG-1:0]      r_pending;
    logic [15:0]          r_stall;

    // Output slot
    logic                 r_slot_vld;
    logic [NUM_UNITS-1:0] r_slot_unit;
    logic [PAYLOAD_W-1:0] r_slot_payload;
    logic [DATA_W-1:0]    r_slot_rega;
    logic [DATA_W-1:0]    r_slot_regb;
    logic [ADDR_W-1:0]    r_slot_regdest;
    logic                 r_slot_writereg;

    logic [PAYLOAD_W-1:0] w_head_payload;
    logic [NUM_UNITS-1:0] w_head_unit;
    logic [ADDR_W-1:0]    w_head_addra;
    logic [ADDR_W-1:0]    w_head_addrb;
    logic                 w_head_check_a;
    logic                 w_head_check_b;
    logic [ADDR_W-1:0]    w_head_regdest;
    logic                 w_head_writereg;

    logic w_full, w_nonempty, w_enq, w_hazard, w_xfer, w_slot_free, w_issue, w_stall_inc, w_sb_set;

    assign w_head_payload  = r_q_payload[r_head];
    assign w_head_unit     = r_q_unit[r_head];
    assign w_head_addra    = r_q_addra[r_head];
    assign w_head_addrb    = r_q_addrb[r_head];
    assign w_head_check_a  = r_q_check_a[r_head];
    assign w_head_check_b  = r_q_check_b[r_head];
    assign w_head_regdest  = r_q_regdest[r_head];
    assign w_head_writereg = r_q_writereg[r_head];

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_nonempty  = (r_count != '0);
    // Flush drops any enqueue or issue attempted in the same cycle.
    assign w_enq       = bus.id_iss_valid && !w_full && !bus.iss_flush;
    // Pending bits are registered, so a writeback this cycle cannot unblock the head until next cycle.
    assign w_hazard    = (w_head_check_a  && r_pending[w_head_addra])
                      || (w_head_check_b  && r_pending[w_head_addrb])
                      || (w_head_writereg && r_pending[w_head_regdest]);
    assign w_xfer      = ((bus.iss_ex_valid & bus.ex_iss_ready) != '0);
    assign w_slot_free = !r_slot_vld || w_xfer;
    assign w_issue     = w_nonempty && !w_hazard && w_slot_free && !bus.iss_flush;
    assign w_stall_inc = w_nonempty && w_slot_free && w_hazard;
    assign w_sb_set    = w_issue && w_head_writereg && (w_head_regdest != '0);

    assign bus.id_iss_ready     = !w_full;
    assign bus.iss_reg_addra    = w_head_addra;
    assign bus.iss_reg_addrb    = w_head_addrb;
    assign bus.iss_ex_valid     = r_slot_vld ? r_slot_unit : '0;
    assign bus.iss_ex_payload   = r_slot_payload;
    assign bus.iss_ex_rega      = r_slot_rega;
    assign bus.iss_ex_regb      = r_slot_regb;
    assign bus.iss_ex_regdest   = r_slot_regdest;
    assign bus.iss_ex_writereg  = r_slot_writereg;
    assign bus.iss_count        = r_count;
    assign bus.iss_stall_cycles = r_stall;

    // Write the incoming instruction at the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_payload[i]  <= '0;
                r_q_unit[i]     <= '0;
                r_q_addra[i]    <= '0;
                r_q_addrb[i]    <= '0;
                r_q_check_a[i]  <= 1'b0;
                r_q_check_b[i]  <= 1'b0;
                r_q_regdest[i]  <= '0;
                r_q_writereg[i] <= 1'b0;
            end
        end else if (w_enq) begin
            r_q_payload[r_tail]  <= bus.id_iss_payload;
            r_q_unit[r_tail]     <= bus.id_iss_unit;
            r_q_addra[r_tail]    <= bus.id_iss_addra;
            r_q_addrb[r_tail]    <= bus.id_iss_addrb;
            r_q_check_a[r_tail]  <= bus.id_iss_check_a;
            r_q_check_b[r_tail]  <= bus.id_iss_check_b;
            r_q_regdest[r_tail]  <= bus.id_iss_regdest;
            r_q_writereg[r_tail] <= bus.id_iss_writereg;
        end
    end

    // Head/tail pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.iss_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)   r_tail <= r_tail + PTR_W'(1);
            if (w_issue) r_head <= r_head + PTR_W'(1);
            case ({w_enq, w_issue})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Scoreboard: set on issue, clear on writeback, set wins; register 0 is never pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending[0] <= 1'b0;
            for (int i = 1; i < NREG; i++) begin
                if (w_sb_set && (w_head_regdest == ADDR_W'(i)))
                    r_pending[i] <= 1'b1;
                else if (bus.wb_iss_valid && (bus.wb_iss_addr == ADDR_W'(i)))
                    r_pending[i] <= 1'b0;
            end
        end
    end

    // Output slot: load on issue, release on transfer, drop on flush; data held while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_vld      <= 1'b0;
            r_slot_unit     <= '0;
            r_slot_payload  <= '0;
            r_slot_rega     <= '0;
            r_slot_regb     <= '0;
            r_slot_regdest  <= '0;
            r_slot_writereg <= 1'b0;
        end else if (bus.iss_flush) begin
            r_slot_vld <= 1'b0;
        end else if (w_issue) begin
            r_slot_vld      <= 1'b1;
            r_slot_unit     <= w_head_unit;
            r_slot_payload  <= w_head_payload;
            r_slot_rega     <= bus.reg_iss_dataa;
            r_slot_regb     <= bus.reg_iss_datab;
            r_slot_regdest  <= w_head_regdest;
            r_slot_writereg <= w_head_writereg;
        end else if (w_xfer) begin
            r_slot_vld <= 1'b0;
        end
    end

    // Saturating count of cycles the head could have issued but for a hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall <= '0;
        else if (w_stall_inc && (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;
    end
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with a scoreboard of expected issues.
// Latency: checks sampled #1 after the rising edge; scoreboard monitor on the falling edge.
// Backpressure: per-unit ready driven directly from the stimulus sequence.
module tb_issue_queue;
    typedef struct {
        logic [2:0]  unit;
        logic [63:0] payload;
        logic [31:0] rega;
        logic [31:0] regb;
        logic [4:0]  regdest;
        logic        wr;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    issue_queue_if #(.DEPTH(4), .DATA_W(32), .ADDR_W(5), .NUM_UNITS(3), .PAYLOAD_W(64)) bus ();

    issue_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5), .NUM_UNITS(3), .PAYLOAD_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] arf_a(input logic [4:0] a);
        return {24'hA0A0A0, 3'b000, a};
    endfunction
    function automatic logic [31:0] arf_b(input logic [4:0] a);
        return {24'hB0B0B0, 3'b000, a};
    endfunction

    // Combinational ARF model
    assign bus.reg_iss_dataa = arf_a(bus.iss_reg_addra);
    assign bus.reg_iss_datab = arf_b(bus.iss_reg_addrb);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] unit, input logic [63:0] pl,
                         input logic [4:0] a, input logic [4:0] b,
                         input logic ca, input logic cb,
                         input logic [4:0] d, input logic wr);
        bus.id_iss_valid    = 1'b1;
        bus.id_iss_unit     = unit;
        bus.id_iss_payload  = pl;
        bus.id_iss_addra    = a;
        bus.id_iss_addrb    = b;
        bus.id_iss_check_a  = ca;
        bus.id_iss_check_b  = cb;
        bus.id_iss_regdest  = d;
        bus.id_iss_writereg = wr;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: pop and compare on each transfer, push on each accepted enqueue.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if ((bus.iss_ex_valid & bus.ex_iss_ready) != 3'b000) begin
                chk("unexpected_issue", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("xfer_unit",    64'(bus.iss_ex_valid),    64'(e.unit));
                    chk("xfer_payload", bus.iss_ex_payload,       e.payload);
                    chk("xfer_rega",    64'(bus.iss_ex_rega),     64'(e.rega));
                    chk("xfer_regb",    64'(bus.iss_ex_regb),     64'(e.regb));
                    chk("xfer_dest_wr", 64'({bus.iss_ex_regdest, bus.iss_ex_writereg}),
                                        64'({e.regdest, e.wr}));
                end
            end
            if (bus.iss_flush) begin
                exp_q.delete();
            end else if (bus.id_iss_valid && bus.id_iss_ready) begin
                exp_t e;
                e.unit    = bus.id_iss_unit;
                e.payload = bus.id_iss_payload;
                e.rega    = arf_a(bus.id_iss_addra);
                e.regb    = arf_b(bus.id_iss_addrb);
                e.regdest = bus.id_iss_regdest;
                e.wr      = bus.id_iss_writereg;
                exp_q.push_back(e);
            end
        end
    end

    initial begin
        logic [15:0] s0;
        int          peak;

        rst = 1'b1;
        drive(3'b001, 64'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        bus.id_iss_valid = 1'b0;
        bus.ex_iss_ready = 3'b111;
        bus.wb_iss_valid = 1'b0;
        bus.wb_iss_addr  = 5'd0;
        bus.iss_flush    = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_ready",   64'(bus.id_iss_ready), 64'd1);
        chk("rst_valid",   64'(bus.iss_ex_valid), 64'd0);
        chk("rst_count",   64'(bus.iss_count), 64'd0);
        chk("rst_stall",   64'(bus.iss_stall_cycles), 64'd0);
        chk("rst_payload", bus.iss_ex_payload, 64'd0);
        chk("rst_rega",    64'(bus.iss_ex_rega), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 64'(bus.id_iss_ready), 64'd1);

        // Four independent ALU ops back to back
        peak = 0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(3'b001, 64'h1000 + 64'(k), 5'd1, 5'd2, 1'b1, 1'b1, 5'(10 + k), 1'b1);
            else       bus.id_iss_valid = 1'b0;
            tick();
            chk($sformatf("t1_valid%0d", k), 64'(bus.iss_ex_valid),
                (k >= 1 && k <= 4) ? 64'd1 : 64'd0);
            if (int'(bus.iss_count) > peak) peak = int'(bus.iss_count);
        end
        chk("t1_peak",  64'(peak), 64'd1);
        chk("t1_stall", 64'(bus.iss_stall_cycles), 64'd0);
        chk("t1_count", 64'(bus.iss_count), 64'd0);

        // Fill while the target unit refuses (other units ready)
        bus.ex_iss_ready = 3'b101;
        for (int i = 0; i < 5; i++) begin
            drive(3'b010, 64'h2000 + 64'(i), 5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0);
            tick();
        end
        chk("t2_count_full", 64'(bus.iss_count), 64'd4);
        chk("t2_ready_low",  64'(bus.id_iss_ready), 64'd0);
        chk("t2_valid",      64'(bus.iss_ex_valid), 64'b010);
        chk("t2_slot",       bus.iss_ex_payload, 64'h2000);
        drive(3'b010, 64'h2005, 5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0);
        tick();
        tick();
        chk("t2_slot_stable", bus.iss_ex_payload, 64'h2000);
        chk("t2_count_hold",  64'(bus.iss_count), 64'd4);
        chk("t2_ready_hold",  64'(bus.id_iss_ready), 64'd0);
        bus.ex_iss_ready = 3'b111;
        tick();
        chk("t2_count_drop", 64'(bus.iss_count), 64'd3);
        chk("t2_next_slot",  bus.iss_ex_payload, 64'h2001);
        tick();
        chk("t2_enq_issue_count", 64'(bus.iss_count), 64'd3);
        bus.id_iss_valid = 1'b0;
        drain("t2_drain", 20);
        chk("t2_empty", 64'(bus.iss_count), 64'd0);

        // RAW dependency on r5 with writeback after three cycles
        s0 = bus.iss_stall_cycles;
        drive(3'b001, 64'h3000, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1);
        tick();
        drive(3'b001, 64'h3001, 5'd5, 5'd3, 1'b1, 1'b0, 5'd6, 1'b0);
        tick();
        bus.id_iss_valid = 1'b0;
        tick();
        chk("t3_blocked", 64'(bus.iss_ex_valid), 64'd0);
        tick();
        tick();
        bus.wb_iss_valid = 1'b1;
        bus.wb_iss_addr  = 5'd5;
        tick();
        bus.wb_iss_valid = 1'b0;
        chk("t3_no_bypass", 64'(bus.iss_ex_valid), 64'd0);
        tick();
        chk("t3_issue",   64'(bus.iss_ex_valid), 64'b001);
        chk("t3_payload", bus.iss_ex_payload, 64'h3001);
        chk("t3_stall",   64'(bus.iss_stall_cycles - s0), 64'd4);
        drain("t3_drain", 10);

        // Writes to r0 never set a pending bit
        s0 = bus.iss_stall_cycles;
        drive(3'b001, 64'h4000, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1);
        tick();
        drive(3'b001, 64'h4001, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1);
        tick();
        chk("t4_first", bus.iss_ex_payload, 64'h4000);
        bus.id_iss_valid = 1'b0;
        tick();
        chk("t4_second_valid", 64'(bus.iss_ex_valid), 64'b001);
        chk("t4_second",       bus.iss_ex_payload, 64'h4001);
        chk("t4_stall",        64'(bus.iss_stall_cycles - s0), 64'd0);
        drain("t4_drain", 10);

        // Flush with three queued, a held slot and a concurrent enqueue
        drive(3'b001, 64'h5000, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1);
        tick();
        drive(3'b001, 64'h5001, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0);
        tick();
        drive(3'b001, 64'h5002, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0);
        tick();
        bus.ex_iss_ready = 3'b000;
        drive(3'b001, 64'h5003, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0);
        tick();
        drive(3'b001, 64'h5004, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0);
        tick();
        chk("t5_pre_count", 64'(bus.iss_count), 64'd3);
        chk("t5_pre_slot",  bus.iss_ex_payload, 64'h5001);
        bus.iss_flush = 1'b1;
        drive(3'b001, 64'h5005, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0);
        tick();
        bus.iss_flush    = 1'b0;
        bus.id_iss_valid = 1'b0;
        chk("t5_count", 64'(bus.iss_count), 64'd0);
        chk("t5_valid", 64'(bus.iss_ex_valid), 64'd0);
        s0 = bus.iss_stall_cycles;
        bus.ex_iss_ready = 3'b111;
        drive(3'b001, 64'h5006, 5'd7, 5'd1, 1'b1, 1'b0, 5'd9, 1'b0);
        tick();
        bus.id_iss_valid = 1'b0;
        tick();
        tick();
        chk("t5_r7_blocked", 64'(bus.iss_ex_valid), 64'd0);
        chk("t5_r7_count",   64'(bus.iss_count), 64'd1);
        chk("t5_r7_stall",   64'(bus.iss_stall_cycles - s0), 64'd2);
        bus.wb_iss_valid = 1'b1;
        bus.wb_iss_addr  = 5'd7;
        tick();
        bus.wb_iss_valid = 1'b0;
        drain("t5_drain", 10);

        // Asynchronous reset with two entries queued
        bus.ex_iss_ready = 3'b000;
        for (int i = 0; i < 3; i++) begin
            drive(3'b001, 64'h6000 + 64'(i), 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1);
            tick();
        end
        bus.id_iss_valid = 1'b0;
        chk("t6_count", 64'(bus.iss_count), 64'd2);
        chk("t6_valid", 64'(bus.iss_ex_valid), 64'b001);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_count",   64'(bus.iss_count), 64'd0);
        chk("t6_rst_valid",   64'(bus.iss_ex_valid), 64'd0);
        chk("t6_rst_payload", bus.iss_ex_payload, 64'd0);
        chk("t6_rst_rega",    64'(bus.iss_ex_rega), 64'd0);
        chk("t6_rst_dest_wr", 64'({bus.iss_ex_regdest, bus.iss_ex_writereg}), 64'd0);
        chk("t6_rst_stall",   64'(bus.iss_stall_cycles), 64'd0);
        chk("t6_rst_ready",   64'(bus.id_iss_ready), 64'd1);
        tick();
        tick();
        rst = 1'b0;
        bus.ex_iss_ready = 3'b111;
        tick();
        chk("t6_post_count", 64'(bus.iss_count), 64'd0);
        chk("final_scoreboard", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
